key_debounce: RTL and testbench

KEY_DEBOUNCE -- requirements
Module: key_debounce

---
 rtl/key_debounce.sv | 136 +++++++++++++
 tb/tb_key_debounce.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_debounce.sv
// key_debounce: debounces an active-low pushbutton and produces a held level plus a
// single-cycle step pulse on each accepted press and on each auto-repeat tick.
//
// Ports:
//   clk     - single rising-edge clock
//   reset   - asynchronous active-low reset (0 = reset)
//   key_n   - raw asynchronous pushbutton, active-low (0 = pressed)
//   pressed - registered debounced key level, 1 = held
//   step    - registered one-cycle pulse per accepted press / auto-repeat
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 10000000,
    parameter int unsigned REPEAT_EN       = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic pressed,
    output logic step
);

    localparam int unsigned MaxDeb = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES
                                                                      : REPEAT_DELAY;
    localparam int unsigned MaxAll = (MaxDeb > REPEAT_PERIOD) ? MaxDeb : REPEAT_PERIOD;
    localparam int unsigned CntW   = $clog2(MaxAll) + 1;

    localparam logic [CntW-1:0] DebLast   = CntW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CntW-1:0] DelayLast = CntW'(REPEAT_DELAY - 1);
    localparam logic [CntW-1:0] PerLast   = CntW'(REPEAT_PERIOD - 1);
    localparam logic [CntW-1:0] CntMax    = '1;

    typedef enum logic [2:0] {
        StIdle,
        StPressWait,
        StHeld,
        StRepeat,
        StReleaseWait
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            sync1_q, sync2_q;
    logic            pressed_q, pressed_d;
    logic            step_q, step_d;
    logic            cnt_clr;
    logic            key_s;

    // Two-flop synchronizer; resets to the released (high) level so reset
    // deassertion never looks like a press edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= key_n;
            sync2_q <= sync1_q;
        end
    end

    assign key_s = ~sync2_q;

    always_comb begin
        state_d = state_q;
        step_d  = 1'b0;
        cnt_clr = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (key_s) state_d = StPressWait;
            end
            StPressWait: begin
                if (!key_s) begin
                    state_d = StIdle;
                end else if (cnt_q == DebLast) begin
                    state_d = StHeld;
                    step_d  = 1'b1;
                end
            end
            StHeld: begin
                if (!key_s) begin
                    state_d = StReleaseWait;
                end else if ((REPEAT_EN != 0) && (cnt_q == DelayLast)) begin
                    state_d = StRepeat;
                    step_d  = 1'b1;
                end
            end
            StRepeat: begin
                // Release is checked first so it wins over a due repeat pulse.
                if (!key_s) begin
                    state_d = StReleaseWait;
                end else if (cnt_q == PerLast) begin
                    step_d  = 1'b1;
                    cnt_clr = 1'b1;
                end
            end
            StReleaseWait: begin
                if (key_s) begin
                    state_d = StHeld;
                end else if (cnt_q == DebLast) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Shared counter: clears on any transition, saturates instead of wrapping.
        if ((state_d != state_q) || cnt_clr) begin
            cnt_d = '0;
        end else if (cnt_q == CntMax) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        pressed_d = (state_d == StHeld) || (state_d == StRepeat) ||
                    (state_d == StReleaseWait);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            pressed_q <= 1'b0;
            step_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pressed_q <= pressed_d;
            step_q    <= step_d;
        end
    end

    assign pressed = pressed_q;
    assign step    = step_q;

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: two instances (auto-repeat on / off) share one stimulus.
// A run-length model predicts pressed/step each cycle; directed scenarios also pin
// hand-computed step/press/release cycle numbers relative to the first low sample.
module tb_key_debounce;

    localparam int unsigned D  = 4;
    localparam int unsigned RD = 10;
    localparam int unsigned RP = 5;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic key_n = 1'b1;
    logic p1, s1, p0, s0;

    always #5 clk = ~clk;

    key_debounce #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP),
        .REPEAT_EN      (1)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .key_n  (key_n),
        .pressed(p1),
        .step   (s1)
    );

    key_debounce #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP),
        .REPEAT_EN      (0)
    ) dut_nr (
        .clk    (clk),
        .reset  (reset),
        .key_n  (key_n),
        .pressed(p0),
        .step   (s0)
    );

    // Model state: delayed key samples, run lengths of the synchronized level,
    // edges since the current hold began, and the predicted outputs.
    typedef struct packed {
        logic        d1;
        logic        d2;
        logic [31:0] ones;
        logic [31:0] zeros;
        logic [31:0] age;
        logic        pressed;
        logic        step;
    } model_t;

    function automatic model_t model_reset();
        model_t m;
        m.d1 = 1'b1; m.d2 = 1'b1;
        m.ones = 0; m.zeros = 0; m.age = 0;
        m.pressed = 1'b0; m.step = 1'b0;
        return m;
    endfunction

    // Accept a press after D+1 consecutive high samples, a release after D+1
    // consecutive low samples; repeats fire RD edges after the hold began and
    // every RP edges after, as long as the level never dropped.
    function automatic model_t model_next(model_t m, logic kn, logic en);
        model_t n = m;
        logic   ks = ~m.d2;
        n.d1   = kn;
        n.d2   = m.d1;
        n.step = 1'b0;
        if (ks) begin
            n.ones  = m.ones + 1;
            n.zeros = 0;
        end else begin
            n.zeros = m.zeros + 1;
            n.ones  = 0;
        end
        if (!m.pressed) begin
            if (n.ones == D + 1) begin
                n.pressed = 1'b1;
                n.step    = 1'b1;
                n.age     = 0;
            end
        end else if (!ks) begin
            if (n.zeros == D + 1) n.pressed = 1'b0;
        end else begin
            n.age = (n.ones == 1) ? 0 : m.age + 1;
            if (en && n.age >= RD && ((n.age - RD) % RP) == 0) n.step = 1'b1;
        end
        return n;
    endfunction

    model_t m1 = model_reset();
    model_t m0 = model_reset();

    int vectors    = 0;
    int miscompares = 0;
    int cyc  = 0;
    int base = 0;
    int q1[$];
    int q0[$];
    int exp_q[$];
    int rise1 = -1, fall1 = -1, rise0 = -1, fall0 = -1;
    logic ps1 = 1'b0, ps0 = 1'b0, pp1 = 1'b0, pp0 = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, got, exp);
        end
    endtask

    task automatic chk_list(input string name, input int got[$], input int exp[$]);
        bit bad = (got.size() != exp.size());
        vectors++;
        if (!bad) begin
            foreach (got[i]) if (got[i] != exp[i]) bad = 1'b1;
        end
        if (bad) begin
            miscompares++;
            $display("FAIL %s: got %p, expected %p", name, got, exp);
        end
    endtask

    // Model advances on the same edge the DUT samples.
    initial forever begin
        @(posedge clk);
        cyc++;
        if (!reset) begin
            m1 = model_reset();
            m0 = model_reset();
        end else begin
            m1 = model_next(m1, key_n, 1'b1);
            m0 = model_next(m0, key_n, 1'b0);
        end
    end

    // Per-cycle compare plus event logging, sampled on the falling edge.
    initial forever begin
        @(negedge clk);
        if (!reset) begin
            chk("rst_pressed", {31'b0, p1}, 0);
            chk("rst_step", {31'b0, s1}, 0);
            chk("rst_pressed_nr", {31'b0, p0}, 0);
            chk("rst_step_nr", {31'b0, s0}, 0);
        end else begin
            chk("pressed", {31'b0, p1}, {31'b0, m1.pressed});
            chk("step", {31'b0, s1}, {31'b0, m1.step});
            chk("pressed_nr", {31'b0, p0}, {31'b0, m0.pressed});
            chk("step_nr", {31'b0, s0}, {31'b0, m0.step});
        end
        if (ps1) chk("step_gap", {31'b0, s1}, 0);
        if (ps0) chk("step_gap_nr", {31'b0, s0}, 0);
        ps1 = s1;
        ps0 = s0;
        if (s1 === 1'b1) q1.push_back(cyc - base);
        if (s0 === 1'b1) q0.push_back(cyc - base);
        if (p1 && !pp1) rise1 = cyc - base;
        if (!p1 && pp1) fall1 = cyc - base;
        if (p0 && !pp0) rise0 = cyc - base;
        if (!p0 && pp0) fall0 = cyc - base;
        pp1 = p1;
        pp0 = p0;
    end

    // Advance n edges, landing 3 time units after the last one.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #3;
        end
    endtask

    // Next edge becomes relative cycle 0.
    task automatic start();
        q1.delete();
        q0.delete();
        rise1 = -1; fall1 = -1; rise0 = -1; fall0 = -1;
        base = cyc + 1;
    endtask

    initial begin
        // Reset and idle: no step on reset release.
        tick(1);
        start();
        tick(3);
        chk("reset_pressed", {31'b0, p1}, 0);
        reset = 1'b1;
        tick(6);
        chk("idle_steps", q1.size(), 0);
        chk("idle_rise", rise1, -1);

        // Clean press, hold with auto-repeat; release lands on a due repeat.
        start();
        key_n = 1'b0;
        tick(39);
        key_n = 1'b1;
        tick(20);
        exp_q = {6, 16, 21, 26, 31, 36};
        chk_list("hold_steps", q1, exp_q);
        exp_q = {6};
        chk_list("hold_steps_nr", q0, exp_q);
        chk("hold_rise", rise1, 6);
        chk("hold_fall", fall1, 45);
        chk("hold_rise_nr", rise0, 6);
        chk("hold_fall_nr", fall0, 45);

        // Press bounce: never accepted.
        start();
        repeat (5) begin
            key_n = 1'b0;
            tick(3);
            key_n = 1'b1;
            tick(1);
        end
        tick(12);
        chk("bounce_steps", q1.size(), 0);
        chk("bounce_rise", rise1, -1);
        chk("bounce_steps_nr", q0.size(), 0);

        // Release bounce: no extra step, release timed from last RELEASE_WAIT entry.
        start();
        key_n = 1'b0;
        tick(8);
        key_n = 1'b1;
        tick(2);
        key_n = 1'b0;
        tick(1);
        key_n = 1'b1;
        tick(15);
        exp_q = {6};
        chk_list("relbounce_steps", q1, exp_q);
        chk_list("relbounce_steps_nr", q0, exp_q);
        chk("relbounce_fall", fall1, 17);
        chk("relbounce_fall_nr", fall0, 17);

        // Reset while repeating with the key still held.
        start();
        key_n = 1'b0;
        tick(19);
        reset = 1'b0;
        #1;
        chk("midrst_pressed", {31'b0, p1}, 0);
        chk("midrst_step", {31'b0, s1}, 0);
        tick(3);
        reset = 1'b1;
        tick(9);
        key_n = 1'b1;
        tick(15);
        exp_q = {6, 16, 28};
        chk_list("midrst_steps", q1, exp_q);
        exp_q = {6, 28};
        chk_list("midrst_steps_nr", q0, exp_q);
        chk("midrst_rise", rise1, 28);
        chk("midrst_fall", fall1, 37);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
